// File: rtl/pov_pkg.sv
// Shared types and constants for the POV command parser slice.
package pov_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        CHK
    } parser_state_t;

    localparam logic [7:0] POV_SYNC_BYTE = 8'hA5;
    localparam int unsigned POV_ADDR_W = 8;

    typedef struct packed {
        logic                  en;
        logic [POV_ADDR_W-1:0] addr;
        logic [7:0]            data;
    } pov_wr_t;

endpackage

// File: rtl/rx_byte_strobe.sv
// Turns the receiver's level done-flag into a one-cycle byte strobe.
module rx_byte_strobe (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_flag,
    output logic       stb,
    output logic [7:0] rx_byte
);

    logic flag_d;

    // Reset to 1 so a flag already high at reset release is not seen as a new byte.
    always_ff @(posedge clk) begin
        if (reset) flag_d <= 1'b1;
        else       flag_d <= rx_flag;
    end

    assign stb     = rx_flag & ~flag_d;
    assign rx_byte = stb ? rx_data : '0;

endmodule

// File: rtl/pov_cmd_parser.sv
// Framed command parser: sync, addr, len, payload writes, optional XOR check.
// Optional checksum byte enabled by defining POV_PARSER_CHECKSUM_EN.
module pov_cmd_parser
    import pov_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter logic [7:0]  SYNC_BYTE      = POV_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_flag,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic              stb;
    logic [7:0]        rx_byte;
    parser_state_t     state;
    logic [ADDR_W-1:0] base;
    logic [7:0]        len;
    logic [7:0]        idx;
    logic [CNT_W-1:0]  tmo_cnt;
`ifdef POV_PARSER_CHECKSUM_EN
    logic [7:0]        chk_acc;
`endif

    rx_byte_strobe u_strobe (
        .clk     (clk),
        .reset   (reset),
        .rx_data (rx_data),
        .rx_flag (rx_flag),
        .stb     (stb),
        .rx_byte (rx_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            base       <= '0;
            len        <= '0;
            idx        <= '0;
            tmo_cnt    <= '0;
`ifdef POV_PARSER_CHECKSUM_EN
            chk_acc    <= '0;
`endif
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (stb) begin
                // A strobe always beats a coincident timeout.
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state <= ADDR;
                            busy  <= 1'b1;
`ifdef POV_PARSER_CHECKSUM_EN
                            chk_acc <= '0;
`endif
                        end
                    end
                    ADDR: begin
                        base  <= ADDR_W'(rx_byte);
                        state <= LEN;
`ifdef POV_PARSER_CHECKSUM_EN
                        chk_acc <= chk_acc ^ rx_byte;
`endif
                    end
                    LEN: begin
                        len <= rx_byte;
                        idx <= '0;
`ifdef POV_PARSER_CHECKSUM_EN
                        chk_acc <= chk_acc ^ rx_byte;
`endif
                        if (rx_byte != 8'd0) begin
                            state <= DATA;
                        end else begin
`ifdef POV_PARSER_CHECKSUM_EN
                            state <= CHK;
`else
                            state      <= IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
`endif
                        end
                    end
                    DATA: begin
                        wr_en   <= 1'b1;
                        wr_addr <= base + ADDR_W'(idx);
                        wr_data <= rx_byte;
                        idx     <= idx + 8'd1;
`ifdef POV_PARSER_CHECKSUM_EN
                        chk_acc <= chk_acc ^ rx_byte;
`endif
                        if (idx == len - 8'd1) begin
`ifdef POV_PARSER_CHECKSUM_EN
                            state <= CHK;
`else
                            state      <= IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
`endif
                        end
                    end
`ifdef POV_PARSER_CHECKSUM_EN
                    CHK: begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= (rx_byte == chk_acc);
                        frame_err  <= (rx_byte != chk_acc);
                    end
`endif
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == CNT_LAST) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    frame_err <= 1'b1;
                    tmo_cnt   <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pov_cmd_parser.sv
// Self-checking bench for pov_cmd_parser; frame-level reference model, random frames.
module tb_pov_cmd_parser;
    import pov_pkg::*;

    localparam int T = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       frame_err;
    logic       busy;

    pov_wr_t obs_w;
    assign obs_w = '{en: wr_en, addr: wr_addr, data: wr_data};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_stb_cyc = 0;
    int mon_wr = 0, mon_done = 0, mon_err = 0;
    int exp_wr = 0, exp_done = 0, exp_err = 0;

    pov_cmd_parser #(
        .ADDR_W         (8),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_flag    (rx_flag),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) mon_wr++;
            if (frame_done) mon_done++;
            if (frame_err) mon_err++;
            if (frame_done || frame_err)
                check("done_err_together", 32'(frame_done & frame_err), 32'd0);
        end
    end

    // Called at a negedge; drives one byte and checks the cycle after its strobe.
    task automatic send_byte(input logic [7:0] b, input bit e_wr, input logic [7:0] e_addr,
                             input bit e_done, input bit e_err, input bit e_busy);
        rx_data = b;
        rx_flag = 1'b1;
        @(negedge clk);
        last_stb_cyc = cyc;
        check("wr_en", 32'(obs_w.en), 32'(e_wr));
        if (e_wr) begin
            check("wr_addr", 32'(obs_w.addr), 32'(e_addr));
            check("wr_data", 32'(obs_w.data), 32'(b));
        end
        check("frame_done", 32'(frame_done), 32'(e_done));
        check("frame_err", 32'(frame_err), 32'(e_err));
        check("busy", 32'(busy), 32'(e_busy));
        @(negedge clk);
        check("pulse_width", {29'd0, wr_en, frame_done, frame_err}, 32'd0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_flag = 1'b0;
        rx_data = 8'($urandom);
        repeat (1 + $urandom_range(0, 3)) @(negedge clk);
    endtask

    // Reference: a frame's meaning follows from byte position alone.
    task automatic send_frame(input logic [7:0] base, input logic [7:0] pl[$], input bit bad);
        logic [7:0] fb[$];
        logic [7:0] x;
        int n;
        n = pl.size();
        fb = {8'hA5, base, 8'(n)};
        x = base ^ 8'(n);
        foreach (pl[i]) begin
            fb.push_back(pl[i]);
            x = x ^ pl[i];
        end
`ifdef POV_PARSER_CHECKSUM_EN
        fb.push_back(bad ? ~x : x);
`endif
        for (int k = 0; k < fb.size(); k++) begin
            bit last, is_pl, good;
            last  = (k == fb.size() - 1);
            is_pl = (k >= 3) && (k < 3 + n);
            good  = 1'b1;
`ifdef POV_PARSER_CHECKSUM_EN
            if (last) good = (fb[k] == x);
`endif
            if (is_pl) exp_wr++;
            if (last && good) exp_done++;
            if (last && !good) exp_err++;
            send_byte(fb[k], is_pl, base + 8'(k - 3), last && good, last && !good, !last);
        end
    endtask

    task automatic send_garbage(input logic [7:0] g);
        send_byte(g, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] g;
        bit found;
        int n;

        reset = 1'b1;
        rx_flag = 1'b1;
        rx_data = 8'hA5;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_done_err", {30'd0, frame_done, frame_err}, 32'd0);
        repeat (3) @(negedge clk);
        check("flag_at_release_busy", 32'(busy), 32'd0);
        rx_flag = 1'b0;
        @(negedge clk);

        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h10, pl, 1'b0);
`ifdef POV_PARSER_CHECKSUM_EN
        send_frame(8'h10, pl, 1'b1);
`endif
        send_frame(8'hFE, pl, 1'b0);
        send_garbage(8'h00);
        send_garbage(8'hFF);
        send_garbage(8'hA4);
        send_frame(8'h10, pl, 1'b0);
        pl = '{8'hA5, 8'hA5};
        send_frame(8'h20, pl, 1'b0);
        pl = {};
        send_frame(8'h40, pl, 1'b0);

        // Timeout partway through the payload.
        send_byte(8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'h11, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
        exp_wr++;
        exp_err++;
        found = 1'b0;
        for (int i = 0; i < T + 20; i++) begin
            if (frame_err) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("timeout_seen", 32'(found), 32'd1);
        if (found) begin
            check("timeout_latency", 32'(cyc - last_stb_cyc), 32'(T));
            check("timeout_busy", 32'(busy), 32'd0);
            check("timeout_no_done", 32'(frame_done), 32'd0);
        end
        @(negedge clk);
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h10, pl, 1'b0);

        // Reset in the middle of the payload.
        send_byte(8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'h03, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'h11, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
        exp_wr++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_done", 32'(mon_done), 32'(exp_done));
        check("mid_reset_err", 32'(mon_err), 32'(exp_err));
        send_frame(8'h30, pl, 1'b0);

        for (int f = 0; f < 10; f++) begin
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                send_garbage(g);
            end
            n = $urandom_range(0, 6);
            pl = {};
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            send_frame(8'($urandom), pl, $urandom_range(0, 3) == 0);
        end

        repeat (4) @(negedge clk);
        check("total_writes", 32'(mon_wr), 32'(exp_wr));
        check("total_done", 32'(mon_done), 32'(exp_done));
        check("total_err", 32'(mon_err), 32'(exp_err));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
